mv_scoreboard: RTL and testbench

Register scoreboard for variable-latency operations: multiply/divide, cache-miss loads and the Busy-generating units. It sits beside the pipeline hazard unit. It tracks up to NUM_TAGS in-flight long-latency results by destination register and stalls Decode on RAW/WAW hazards against them. It also returns the destination register when a unit completes, so units need not carry rd. Its stall output is ORed into StallF/StallD; load-use stalling, forwarding and branch flushing remain with the hazard unit.

---
 rtl/mv_pkg.sv | 32 +++
 rtl/mv_prio_enc.sv | 24 ++
 rtl/mv_scoreboard.sv | 115 +++++++++++
 tb/tb_mv_scoreboard.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/mv_pkg.sv
// Shared decode constants for the multiply/divide and long-latency scoreboard slice.
// Helpers let Decode derive rs*_usedD and long_opD from the raw instruction fields.
package mv_pkg;

    localparam int unsigned DEF_NUM_TAGS = 4;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

    function automatic logic usesRs1(input logic [6:0] opcode);
        return !(opcode == OP_JAL || opcode == OP_LUI || opcode == OP_AUIPC);
    endfunction

    function automatic logic usesRs2(input logic [6:0] opcode);
        return (opcode == OP_OP || opcode == OP_STORE || opcode == OP_BRANCH);
    endfunction

    // Loads are treated as long ops because a cache miss returns with unknown latency.
    function automatic logic isLongOp(input logic [6:0] opcode, input logic [6:0] funct7);
        return (opcode == OP_LOAD) || (opcode == OP_OP && funct7 == FUNCT7_MULDIV);
    endfunction

endpackage

// File: rtl/mv_prio_enc.sv
// Lowest-free-index priority encoder over a busy vector.
// allBusy flags that no index is free; idx is 0 in that case.
module mv_prio_enc #(
    parameter int unsigned N = 4,
    parameter int unsigned W = $clog2(N)
) (
    input  logic [N-1:0] busy,
    output logic [W-1:0] idx,
    output logic         allBusy
);

    // Scan from the top so the last hit written is the lowest free index.
    always_comb begin
        idx = '0;
        for (int unsigned i = N; i > 0; i--) begin
            if (!busy[i-1]) begin
                idx = W'(i - 1);
            end
        end
    end

    assign allBusy = &busy;

endmodule

// File: rtl/mv_scoreboard.sv
// Register scoreboard for variable-latency units: tracks in-flight destinations by tag,
// stalls Decode on RAW/WAW/structural hazards and returns rd on completion.
module mv_scoreboard
    import mv_pkg::*;
#(
    parameter int unsigned NREG     = 32,
    parameter int unsigned NUM_TAGS = DEF_NUM_TAGS,
    parameter int unsigned RW       = $clog2(NREG),
    parameter int unsigned TW       = $clog2(NUM_TAGS)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          dec_valid,
    input  logic [RW-1:0] rs1D,
    input  logic [RW-1:0] rs2D,
    input  logic          rs1_usedD,
    input  logic          rs2_usedD,
    input  logic [RW-1:0] rdD,
    input  logic          rd_wrD,
    input  logic          long_opD,
    input  logic          iss_valid,
    input  logic [RW-1:0] iss_rd,
    input  logic          flush,
    output logic [TW-1:0] iss_tag,
    input  logic          cmp_valid,
    input  logic [TW-1:0] cmp_tag,
    output logic [RW-1:0] cmp_rd,
    output logic          sb_stall,
    output logic          full,
    output logic [TW:0]   occupancy,
    output logic          err_overflow,
    output logic          err_badcmp
);

    logic [NUM_TAGS-1:0] valid;
    logic [RW-1:0]       rdTab [NUM_TAGS];
    logic [TW:0]         occ;
    logic [TW-1:0]       allocTag;
    logic                allBusy;
    logic                cmpInRange;
    logic                cmpHit;
    logic                doIssue;
    logic                raw;
    logic                waw;
    logic                structHaz;

    mv_prio_enc #(
        .N(NUM_TAGS),
        .W(TW)
    ) uAlloc (
        .busy   (valid),
        .idx    (allocTag),
        .allBusy(allBusy)
    );

    assign full      = allBusy;
    assign iss_tag   = allocTag;
    assign occupancy = occ;
    assign doIssue   = iss_valid && !flush && !allBusy;

    always_comb begin
        cmpInRange = (32'(cmp_tag) < NUM_TAGS);
        cmpHit     = 1'b0;
        cmp_rd     = '0;
        if (cmpInRange) begin
            cmpHit = cmp_valid && valid[cmp_tag];
            cmp_rd = rdTab[cmp_tag];
        end
    end

    // x0 entries are tracked for occupancy but never match as a hazard.
    always_comb begin
        raw = 1'b0;
        waw = 1'b0;
        for (int unsigned i = 0; i < NUM_TAGS; i++) begin
            if (valid[i] && rdTab[i] != '0) begin
                if (rs1_usedD && rdTab[i] == rs1D) raw = 1'b1;
                if (rs2_usedD && rdTab[i] == rs2D) raw = 1'b1;
                if (rd_wrD && rdTab[i] == rdD)     waw = 1'b1;
            end
        end
        structHaz = long_opD && allBusy;
        sb_stall  = dec_valid && (raw || waw || structHaz);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid        <= '0;
            occ          <= '0;
            err_overflow <= 1'b0;
            err_badcmp   <= 1'b0;
            for (int unsigned i = 0; i < NUM_TAGS; i++) begin
                rdTab[i] <= '0;
            end
        end else begin
            // Issue only targets a free tag and completion only a used one, so they never collide.
            for (int unsigned i = 0; i < NUM_TAGS; i++) begin
                if (doIssue && allocTag == TW'(i)) begin
                    valid[i] <= 1'b1;
                    rdTab[i] <= iss_rd;
                end else if (cmpHit && cmp_tag == TW'(i)) begin
                    valid[i] <= 1'b0;
                end
            end
            case ({doIssue, cmpHit})
                2'b10:   occ <= occ + 1'b1;
                2'b01:   occ <= occ - 1'b1;
                default: occ <= occ;
            endcase
            if (iss_valid && !flush && allBusy) err_overflow <= 1'b1;
            if (cmp_valid && !cmpHit)           err_badcmp   <= 1'b1;
        end
    end

endmodule

// File: tb/tb_mv_scoreboard.sv
// Directed self-checking bench for mv_scoreboard (NUM_TAGS=4, NREG=32).
module tb_mv_scoreboard;

    localparam int unsigned NREG     = 32;
    localparam int unsigned NUM_TAGS = 4;
    localparam int unsigned RW       = 5;
    localparam int unsigned TW       = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          dec_valid;
    logic [RW-1:0] rs1D, rs2D, rdD;
    logic          rs1_usedD, rs2_usedD, rd_wrD, long_opD;
    logic          iss_valid;
    logic [RW-1:0] iss_rd;
    logic          flush;
    logic [TW-1:0] iss_tag;
    logic          cmp_valid;
    logic [TW-1:0] cmp_tag;
    logic [RW-1:0] cmp_rd;
    logic          sb_stall, full, err_overflow, err_badcmp;
    logic [TW:0]   occupancy;

    int checks = 0;
    int errors = 0;

    mv_scoreboard #(
        .NREG    (NREG),
        .NUM_TAGS(NUM_TAGS)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .dec_valid   (dec_valid),
        .rs1D        (rs1D),
        .rs2D        (rs2D),
        .rs1_usedD   (rs1_usedD),
        .rs2_usedD   (rs2_usedD),
        .rdD         (rdD),
        .rd_wrD      (rd_wrD),
        .long_opD    (long_opD),
        .iss_valid   (iss_valid),
        .iss_rd      (iss_rd),
        .flush       (flush),
        .iss_tag     (iss_tag),
        .cmp_valid   (cmp_valid),
        .cmp_tag     (cmp_tag),
        .cmp_rd      (cmp_rd),
        .sb_stall    (sb_stall),
        .full        (full),
        .occupancy   (occupancy),
        .err_overflow(err_overflow),
        .err_badcmp  (err_badcmp)
    );

    always #5 clk = ~clk;

    task automatic idle();
        dec_valid = 0; rs1D = 0; rs2D = 0; rdD = 0;
        rs1_usedD = 0; rs2_usedD = 0; rd_wrD = 0; long_opD = 0;
        iss_valid = 0; iss_rd = 0; flush = 0; cmp_valid = 0; cmp_tag = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        idle();
        rst_n = 0;
        iss_valid = 1; iss_rd = 5;
        dec_valid = 1; rs1D = 5; rs1_usedD = 1; long_opD = 1;
        tick(); tick();
        checks++; if (occupancy !== 3'd0) begin errors++; $display("FAIL reset_occ got=%0d exp=0", occupancy); end
        checks++; if (sb_stall !== 1'b0) begin errors++; $display("FAIL reset_stall got=%b exp=0", sb_stall); end
        checks++; if ({err_overflow, err_badcmp, full} !== 3'b000) begin errors++; $display("FAIL reset_flags got=%b exp=000", {err_overflow, err_badcmp, full}); end
        checks++; if ({iss_tag, cmp_rd} !== 7'd0) begin errors++; $display("FAIL reset_tag_rd got=%0d/%0d exp=0/0", iss_tag, cmp_rd); end
        idle();
        rst_n = 1;
        iss_valid = 1; iss_rd = 5;
        #1;
        checks++; if (iss_tag !== 2'd0) begin errors++; $display("FAIL first_iss_tag got=%0d exp=0", iss_tag); end
        tick();
        idle();
        checks++; if (occupancy !== 3'd1) begin errors++; $display("FAIL first_iss_occ got=%0d exp=1", occupancy); end
    endtask

    task automatic test_raw();
        dec_valid = 1; rs1D = 5; rs1_usedD = 1;
        #1;
        checks++; if (sb_stall !== 1'b1) begin errors++; $display("FAIL raw_rs1 got=%b exp=1", sb_stall); end
        rs1_usedD = 0; rs2D = 5; rs2_usedD = 1;
        #1;
        checks++; if (sb_stall !== 1'b1) begin errors++; $display("FAIL raw_rs2 got=%b exp=1", sb_stall); end
        rs2_usedD = 0; rs1D = 6; rs1_usedD = 1;
        #1;
        checks++; if (sb_stall !== 1'b0) begin errors++; $display("FAIL raw_other_reg got=%b exp=0", sb_stall); end
        rs1D = 5;
        cmp_valid = 1; cmp_tag = 0;
        #1;
        checks++; if (cmp_rd !== 5'd5) begin errors++; $display("FAIL raw_cmp_rd got=%0d exp=5", cmp_rd); end
        checks++; if (sb_stall !== 1'b1) begin errors++; $display("FAIL raw_same_cycle_stall got=%b exp=1", sb_stall); end
        tick();
        cmp_valid = 0;
        #1;
        checks++; if (sb_stall !== 1'b0) begin errors++; $display("FAIL raw_release got=%b exp=0", sb_stall); end
        checks++; if (occupancy !== 3'd0) begin errors++; $display("FAIL raw_occ got=%0d exp=0", occupancy); end
        idle();
    endtask

    task automatic test_waw_x0();
        iss_valid = 1; iss_rd = 7;
        tick();
        iss_valid = 0;
        dec_valid = 1; rdD = 7; rd_wrD = 1;
        #1;
        checks++; if (sb_stall !== 1'b1) begin errors++; $display("FAIL waw_stall got=%b exp=1", sb_stall); end
        rd_wrD = 0;
        #1;
        checks++; if (sb_stall !== 1'b0) begin errors++; $display("FAIL waw_nowrite got=%b exp=0", sb_stall); end
        iss_valid = 1; iss_rd = 0;
        #1;
        checks++; if (iss_tag !== 2'd1) begin errors++; $display("FAIL x0_iss_tag got=%0d exp=1", iss_tag); end
        tick();
        iss_valid = 0;
        rs1D = 0; rs1_usedD = 1; rdD = 0; rd_wrD = 1;
        #1;
        checks++; if (sb_stall !== 1'b0) begin errors++; $display("FAIL x0_no_stall got=%b exp=0", sb_stall); end
        checks++; if (occupancy !== 3'd2) begin errors++; $display("FAIL x0_occ got=%0d exp=2", occupancy); end
        idle();
        cmp_valid = 1; cmp_tag = 0; tick();
        cmp_tag = 1; tick();
        idle();
        checks++; if (occupancy !== 3'd0) begin errors++; $display("FAIL waw_drain_occ got=%0d exp=0", occupancy); end
    endtask

    task automatic test_full();
        for (int i = 1; i <= 4; i++) begin
            iss_valid = 1; iss_rd = 5'(i);
            #1;
            checks++; if (iss_tag !== 2'(i - 1)) begin errors++; $display("FAIL full_alloc%0d got=%0d exp=%0d", i, iss_tag, i - 1); end
            tick();
        end
        idle();
        checks++; if ({full, occupancy} !== {1'b1, 3'd4}) begin errors++; $display("FAIL full_state got=%b/%0d exp=1/4", full, occupancy); end
        dec_valid = 1; long_opD = 1; rs1D = 6; rs1_usedD = 1;
        #1;
        checks++; if (sb_stall !== 1'b1) begin errors++; $display("FAIL full_struct got=%b exp=1", sb_stall); end
        long_opD = 0;
        #1;
        checks++; if (sb_stall !== 1'b0) begin errors++; $display("FAIL full_nonlong got=%b exp=0", sb_stall); end
        idle();
        iss_valid = 1; iss_rd = 9;
        tick();
        idle();
        checks++; if (err_overflow !== 1'b1) begin errors++; $display("FAIL overflow_flag got=%b exp=1", err_overflow); end
        checks++; if (occupancy !== 3'd4) begin errors++; $display("FAIL overflow_occ got=%0d exp=4", occupancy); end
    endtask

    task automatic test_simultaneous();
        cmp_valid = 1; cmp_tag = 2;
        iss_valid = 1; iss_rd = 10;
        #1;
        checks++; if (cmp_rd !== 5'd3) begin errors++; $display("FAIL simul_cmp_rd got=%0d exp=3", cmp_rd); end
        tick();
        idle();
        checks++; if ({full, occupancy} !== {1'b0, 3'd3}) begin errors++; $display("FAIL simul_state got=%b/%0d exp=0/3", full, occupancy); end
        checks++; if (err_overflow !== 1'b1) begin errors++; $display("FAIL overflow_sticky got=%b exp=1", err_overflow); end
        iss_valid = 1; iss_rd = 10;
        #1;
        checks++; if (iss_tag !== 2'd2) begin errors++; $display("FAIL simul_realloc got=%0d exp=2", iss_tag); end
        tick();
        idle();
        dec_valid = 1; rdD = 10; rd_wrD = 1;
        #1;
        checks++; if ({sb_stall, occupancy} !== {1'b1, 3'd4}) begin errors++; $display("FAIL simul_pending10 got=%b/%0d exp=1/4", sb_stall, occupancy); end
        idle();
        for (int t = 0; t < 4; t++) begin
            logic [4:0] expRd;
            expRd = (t == 2) ? 5'd10 : 5'(t + 1);
            cmp_valid = 1; cmp_tag = 2'(t);
            #1;
            checks++; if (cmp_rd !== expRd) begin errors++; $display("FAIL drain_cmp_rd%0d got=%0d exp=%0d", t, cmp_rd, expRd); end
            tick();
        end
        idle();
        checks++; if ({occupancy, err_badcmp} !== {3'd0, 1'b0}) begin errors++; $display("FAIL drain_state got=%0d/%b exp=0/0", occupancy, err_badcmp); end
    endtask

    task automatic test_flush();
        iss_valid = 1; flush = 1; iss_rd = 9;
        tick();
        idle();
        dec_valid = 1; rs1D = 9; rs1_usedD = 1;
        #1;
        checks++; if ({sb_stall, occupancy, iss_tag} !== {1'b0, 3'd0, 2'd0}) begin errors++; $display("FAIL flush_ignored got=%b/%0d/%0d exp=0/0/0", sb_stall, occupancy, iss_tag); end
        idle();
        cmp_valid = 1; cmp_tag = 3;
        tick();
        idle();
        checks++; if ({err_badcmp, occupancy} !== {1'b1, 3'd0}) begin errors++; $display("FAIL badcmp got=%b/%0d exp=1/0", err_badcmp, occupancy); end
    endtask

    task automatic test_back_to_back();
        iss_valid = 1; iss_rd = 12;
        tick();
        iss_rd = 13; cmp_valid = 1; cmp_tag = 0;
        #1;
        checks++; if ({iss_tag, cmp_rd} !== {2'd1, 5'd12}) begin errors++; $display("FAIL b2b_tag_rd got=%0d/%0d exp=1/12", iss_tag, cmp_rd); end
        tick();
        idle();
        checks++; if (occupancy !== 3'd1) begin errors++; $display("FAIL b2b_occ got=%0d exp=1", occupancy); end
        checks++; if (iss_tag !== 2'd0) begin errors++; $display("FAIL b2b_freed_tag got=%0d exp=0", iss_tag); end
        #2;
        rst_n = 0;
        #1;
        checks++; if ({occupancy, err_badcmp, err_overflow} !== {3'd0, 2'b00}) begin errors++; $display("FAIL midop_reset got=%0d/%b/%b exp=0/0/0", occupancy, err_badcmp, err_overflow); end
        tick();
        rst_n = 1;
    endtask

    initial begin
        idle();
        rst_n = 0;
        test_reset();
        test_raw();
        test_waw_x0();
        test_full();
        test_simultaneous();
        test_flush();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
